barrel_shift_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter/rotator with valid/ready handshake on input and output.
- Supports four operations: rotate left/right and logical shift left/right, for any power-of-two data width.
- Uses one register stage per shift-amount bit, giving full throughput of one operation per cycle with backpressure.
- Sits between a streaming producer (e.g. the ALU operand path) and its consumer, in place of the single-cycle combinational shifters.

---
 rtl/barrel_shift_pipe_if.sv | 26 ++
 rtl/barrel_shift_pipe.sv | 163 ++++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_pipe_if.sv
// Stream bundle for barrel_shift_pipe: operation request in, shifted result out.
// Signal names are from the shifter's point of view; the slave modport is the shifter.
interface barrel_shift_pipe_if #(
  parameter int BIT = 8
);
  localparam int SH = $clog2(BIT);

  logic           i_valid;
  logic           o_ready;
  logic [BIT-1:0] i_data;
  logic [1:0]     i_mode;
  logic [SH-1:0]  i_shifter;
  logic           o_valid;
  logic           i_ready;
  logic [BIT-1:0] o_data;

  modport slave (
    input  i_valid, i_data, i_mode, i_shifter, i_ready,
    output o_ready, o_valid, o_data
  );

  modport master (
    output i_valid, i_data, i_mode, i_shifter, i_ready,
    input  o_ready, o_valid, o_data
  );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator (ROL/ROR/SLL/SRL), one stage per amount bit, MSB step first.
// Optional BARREL_SHIFT_PIPE_SKID_EN puts a registered-ready skid buffer in front of stage 0.
module barrel_shift_pipe #(
  parameter int BIT = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  barrel_shift_pipe_if.slave   io_bus
);
  localparam int SH = $clog2(BIT);

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;

  // Rotates use a doubled word so the wrapped bits fall out of a plain shift.
  function automatic logic [BIT-1:0] f_step(input logic [BIT-1:0] d,
                                            input logic [1:0]     m,
                                            input int             s);
    logic [2*BIT-1:0] w_dbl;
    w_dbl = {d, d};
    case (m)
      MODE_ROL: begin
        w_dbl  = w_dbl << s;
        f_step = w_dbl[2*BIT-1:BIT];
      end
      MODE_ROR: begin
        w_dbl  = w_dbl >> s;
        f_step = w_dbl[BIT-1:0];
      end
      MODE_SLL: f_step = d << s;
      default:  f_step = d >> s;
    endcase
  endfunction

  logic [SH:0]    w_ready;
  logic           w_in_valid [SH];
  logic [BIT-1:0] w_in_data  [SH];
  logic [1:0]     w_in_mode  [SH];
  logic [SH-1:0]  w_in_amt   [SH];

  logic           w_src_valid;
  logic [BIT-1:0] w_src_data;
  logic [1:0]     w_src_mode;
  logic [SH-1:0]  w_src_amt;

  assign w_ready[SH]   = io_bus.i_ready;
  assign w_in_valid[0] = w_src_valid;
  assign w_in_data[0]  = w_src_data;
  assign w_in_mode[0]  = w_src_mode;
  assign w_in_amt[0]   = w_src_amt;

  genvar gi;
  generate
    for (gi = 0; gi < SH; gi++) begin : g_stage
      localparam int BSEL = SH - 1 - gi;
      localparam int STEP = 1 << BSEL;

      logic           r_valid;
      logic [BIT-1:0] r_data;
      logic [BIT-1:0] w_next;

      assign w_next      = w_in_amt[gi][BSEL] ? f_step(w_in_data[gi], w_in_mode[gi], STEP)
                                              : w_in_data[gi];
      assign w_ready[gi] = !r_valid || w_ready[gi+1];

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_ready[gi]) begin
          r_valid <= w_in_valid[gi];
          r_data  <= w_next;
        end
      end

      if (gi < SH - 1) begin : g_fwd
        logic [1:0]    r_mode;
        logic [SH-1:0] r_amt;

        always_ff @(posedge i_clk or negedge i_rstn) begin
          if (!i_rstn) begin
            r_mode <= '0;
            r_amt  <= '0;
          end else if (w_ready[gi]) begin
            r_mode <= w_in_mode[gi];
            r_amt  <= w_in_amt[gi];
          end
        end

        assign w_in_valid[gi+1] = r_valid;
        assign w_in_data[gi+1]  = r_data;
        assign w_in_mode[gi+1]  = r_mode;
        assign w_in_amt[gi+1]   = r_amt;
      end else begin : g_last
        assign io_bus.o_valid = r_valid;
        assign io_bus.o_data  = r_data;
      end
    end
  endgenerate

`ifdef BARREL_SHIFT_PIPE_SKID_EN
  logic [1:0]     r_sk_cnt;
  logic [1:0]     w_sk_cnt_next;
  logic           r_o_ready;
  logic [BIT-1:0] r_sk_data [2];
  logic [1:0]     r_sk_mode [2];
  logic [SH-1:0]  r_sk_amt  [2];
  logic           w_push;
  logic           w_bypass;
  logic           w_pop;
  logic           w_enq;
  logic           w_wr_idx;

  assign w_push        = io_bus.i_valid && r_o_ready;
  assign w_bypass      = (r_sk_cnt == 2'd0);
  assign w_pop         = !w_bypass && w_ready[0];
  assign w_enq         = w_push && !(w_bypass && w_ready[0]);
  assign w_wr_idx      = (r_sk_cnt == 2'd1) && !w_pop;
  assign w_sk_cnt_next = r_sk_cnt + {1'b0, w_enq} - {1'b0, w_pop};

  // An empty skid forwards the request straight into stage 0, keeping latency at SH.
  assign w_src_valid = w_bypass ? w_push         : 1'b1;
  assign w_src_data  = w_bypass ? io_bus.i_data    : r_sk_data[0];
  assign w_src_mode  = w_bypass ? io_bus.i_mode    : r_sk_mode[0];
  assign w_src_amt   = w_bypass ? io_bus.i_shifter : r_sk_amt[0];

  assign io_bus.o_ready = r_o_ready;

  // Ready is taken from the next occupancy, so it closes once one request is parked.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sk_cnt  <= '0;
      r_o_ready <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_sk_data[i] <= '0;
        r_sk_mode[i] <= '0;
        r_sk_amt[i]  <= '0;
      end
    end else begin
      r_sk_cnt  <= w_sk_cnt_next;
      r_o_ready <= (w_sk_cnt_next == 2'd0);
      if (w_pop) begin
        r_sk_data[0] <= r_sk_data[1];
        r_sk_mode[0] <= r_sk_mode[1];
        r_sk_amt[0]  <= r_sk_amt[1];
      end
      if (w_enq) begin
        r_sk_data[w_wr_idx] <= io_bus.i_data;
        r_sk_mode[w_wr_idx] <= io_bus.i_mode;
        r_sk_amt[w_wr_idx]  <= io_bus.i_shifter;
      end
    end
  end
`else
  assign w_src_valid    = io_bus.i_valid;
  assign w_src_data     = io_bus.i_data;
  assign w_src_mode     = io_bus.i_mode;
  assign w_src_amt      = io_bus.i_shifter;
  assign io_bus.o_ready = w_ready[0] && i_rstn;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Self-checking bench for barrel_shift_pipe: directed vectors on 8- and 16-bit instances,
// streaming, backpressure, random handshake and mid-stream reset on the 8-bit instance.
module tb_barrel_shift_pipe;
  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  barrel_shift_pipe_if #(.BIT(8))  bus8  ();
  barrel_shift_pipe_if #(.BIT(16)) bus16 ();

  barrel_shift_pipe #(.BIT(8))  dut8  (.i_clk(clk), .i_rstn(rstn), .io_bus(bus8));
  barrel_shift_pipe #(.BIT(16)) dut16 (.i_clk(clk), .i_rstn(rstn), .io_bus(bus16));

`ifdef BARREL_SHIFT_PIPE_SKID_EN
  localparam int CAP8 = 4;
`else
  localparam int CAP8 = 3;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_out8   = 0;
  logic [7:0] exp_q[$];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp_v);
    end
  endtask

  // Bit-by-bit reference, written from the per-bit definitions of each operation.
  function automatic logic [7:0] ref8(input logic [7:0] d, input logic [1:0] m, input int s);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      case (m)
        2'b00:   r[i] = d[(i - s + 8) % 8];
        2'b01:   r[i] = d[(i + s) % 8];
        2'b10:   r[i] = (i >= s) ? d[i - s] : 1'b0;
        default: r[i] = (i + s < 8) ? d[i + s] : 1'b0;
      endcase
    end
    return r;
  endfunction

  // Scoreboard and stall-stability monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
      hold_pend <= 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", bus8.o_valid, 1);
        check("hold_data", bus8.o_data, hold_data);
      end
      hold_pend <= bus8.o_valid && !bus8.i_ready;
      hold_data <= bus8.o_data;
      if (bus8.o_valid && bus8.i_ready) begin
        n_out8 <= n_out8 + 1;
        if (exp_q.size() == 0) check("sb_unexpected", exp_q.size(), 1);
        else                   check("sb_data", bus8.o_data, exp_q.pop_front());
      end
      if (bus8.i_valid && bus8.o_ready)
        exp_q.push_back(ref8(bus8.i_data, bus8.i_mode, int'(bus8.i_shifter)));
    end
  end

  task automatic op8(input string tag, input logic [7:0] d, input logic [1:0] m,
                     input logic [2:0] s, input logic [7:0] exp_v);
    int lat;
    @(posedge clk); #1;
    bus8.i_valid = 1'b1; bus8.i_data = d; bus8.i_mode = m; bus8.i_shifter = s;
    @(negedge clk);
    check({tag, "_rdy"}, bus8.o_ready, 1);
    @(posedge clk); #1;
    bus8.i_valid = 1'b0;
    lat = 1;
    while (!bus8.o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_data"}, bus8.o_data, exp_v);
    $display("op8 %s: in=0x%02h mode=%0d amt=%0d out=0x%02h lat=%0d", tag, d, m, s, bus8.o_data, lat);
  endtask

  task automatic op16(input string tag, input logic [15:0] d, input logic [1:0] m,
                      input logic [3:0] s, input logic [15:0] exp_v);
    int lat;
    @(posedge clk); #1;
    bus16.i_valid = 1'b1; bus16.i_data = d; bus16.i_mode = m; bus16.i_shifter = s;
    @(negedge clk);
    check({tag, "_rdy"}, bus16.o_ready, 1);
    @(posedge clk); #1;
    bus16.i_valid = 1'b0;
    lat = 1;
    while (!bus16.o_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_data"}, bus16.o_data, exp_v);
    $display("op16 %s: in=0x%04h mode=%0d amt=%0d out=0x%04h lat=%0d", tag, d, m, s, bus16.o_data, lat);
  endtask

  task automatic drain8(input string tag);
    for (int k = 0; k < 40 && (exp_q.size() != 0 || bus8.o_valid); k++) begin
      @(posedge clk); #1;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int idx;
    int pushed;
    int seen;
    logic acc;

    rstn = 1'b0;
    bus8.i_valid = 1'b0;  bus8.i_data = '0;  bus8.i_mode = '0;  bus8.i_shifter = '0;  bus8.i_ready = 1'b1;
    bus16.i_valid = 1'b0; bus16.i_data = '0; bus16.i_mode = '0; bus16.i_shifter = '0; bus16.i_ready = 1'b1;

    #2;
    check("rst_o_valid", bus8.o_valid, 0);
    check("rst_o_data", bus8.o_data, 0);
    check("rst_o_ready", bus8.o_ready, 0);
    check("rst_o_ready16", bus16.o_ready, 0);
    #10 rstn = 1'b1;
    @(negedge clk);
    check("rel_o_ready", bus8.o_ready, 1);
    $display("reset: o_valid=%0d o_ready=%0d", bus8.o_valid, bus8.o_ready);

    op8("rol1",  8'h81, 2'b00, 3'd1, 8'h03);
    op8("ror1",  8'h01, 2'b01, 3'd1, 8'h80);
    op8("sll3",  8'hFF, 2'b10, 3'd3, 8'hF8);
    op8("srl7",  8'h80, 2'b11, 3'd7, 8'h01);
    op8("rol0",  8'hA5, 2'b00, 3'd0, 8'hA5);
    op8("ror0",  8'hA5, 2'b01, 3'd0, 8'hA5);
    op8("sll0",  8'hA5, 2'b10, 3'd0, 8'hA5);
    op8("srl0",  8'hA5, 2'b11, 3'd0, 8'hA5);
    op8("rol3",  8'h96, 2'b00, 3'd3, 8'hB4);
    op8("ror4",  8'h81, 2'b01, 3'd4, 8'h18);
    op8("sll7",  8'h81, 2'b10, 3'd7, 8'h80);
    op8("srl2",  8'hA5, 2'b11, 3'd2, 8'h29);
    op16("rol15", 16'h8001, 2'b00, 4'd15, 16'hC000);
    op16("srl8",  16'hFFFF, 2'b11, 4'd8,  16'h00FF);
    drain8("directed");

    // 100 back-to-back random operations with i_ready held high.
    base = n_out8;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      bus8.i_valid = 1'b1;
      bus8.i_data = 8'($urandom); bus8.i_mode = 2'($urandom); bus8.i_shifter = 3'($urandom);
    end
    @(posedge clk); #1;
    bus8.i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_count", n_out8 - base, 100);
    $display("stream: %0d results", n_out8 - base);
    drain8("stream");

    // Backpressure: 6 stalled cycles while offering 5 operations.
    base = n_out8;
    idx = 0;
    @(posedge clk); #1;
    bus8.i_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      bus8.i_valid = (idx < 5);
      bus8.i_data = 8'(8'h13 + idx * 8'h21); bus8.i_mode = 2'(idx); bus8.i_shifter = 3'(idx + 1);
      @(negedge clk);
      if (bus8.i_valid && bus8.o_ready) idx++;
    end
    check("bp_accepted", idx, CAP8);
    check("bp_ready_low", bus8.o_ready, 0);
    check("bp_out_none", n_out8 - base, 0);
    $display("backpressure: accepted=%0d o_ready=%0d", idx, bus8.o_ready);
    @(posedge clk); #1;
    bus8.i_ready = 1'b1;
    for (int c = 0; c < 50 && idx < 5; c++) begin
      bus8.i_valid = 1'b1;
      bus8.i_data = 8'(8'h13 + idx * 8'h21); bus8.i_mode = 2'(idx); bus8.i_shifter = 3'(idx + 1);
      @(negedge clk);
      if (bus8.o_ready) idx++;
      @(posedge clk); #1;
    end
    bus8.i_valid = 1'b0;
    drain8("bp");
    check("bp_out_count", n_out8 - base, 5);
    $display("backpressure drain: %0d results", n_out8 - base);

    // Random valid/ready toggling; requests are held until accepted.
    base = n_out8;
    pushed = 0;
    acc = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      bus8.i_ready = 1'($urandom_range(0, 1));
      if (!bus8.i_valid || acc) begin
        bus8.i_valid = 1'($urandom_range(0, 1));
        bus8.i_data = 8'($urandom); bus8.i_mode = 2'($urandom); bus8.i_shifter = 3'($urandom);
      end
      @(negedge clk);
      acc = bus8.i_valid && bus8.o_ready;
      if (acc) pushed++;
    end
    @(posedge clk); #1;
    bus8.i_valid = 1'b0;
    bus8.i_ready = 1'b1;
    drain8("rand");
    check("rand_count", n_out8 - base, pushed);
    $display("random: accepted=%0d emitted=%0d", pushed, n_out8 - base);

    // Reset with three operations in flight.
    @(posedge clk); #1;
    bus8.i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      bus8.i_valid = 1'b1; bus8.i_data = 8'h5A; bus8.i_mode = 2'b00; bus8.i_shifter = 3'(k + 1);
    end
    @(posedge clk); #1;
    bus8.i_valid = 1'b0;
    check("pre_rst_valid", bus8.o_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_o_valid", bus8.o_valid, 0);
    check("mid_rst_o_data", bus8.o_data, 0);
    check("mid_rst_o_ready", bus8.o_ready, 0);
    @(negedge clk); #2;
    rstn = 1'b1;
    bus8.i_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", bus8.o_ready, 1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      seen += int'(bus8.o_valid);
    end
    check("post_rst_no_stale", seen, 0);
    $display("mid reset: stale outputs seen=%0d", seen);

    check("final_queue", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
